change_dispenser: RTL and testbench
===================================

# change_dispenser

Coin payout unit on the far end of the vending controller's change interface. It captures a change request (`return_change` plus `change_value`) and breaks the amount into coins with a greedy algorithm. It tracks per-denomination inventory and drives a coin hopper through a valid/ready eject handshake. When the payout ends it reports completion, shortfall or hopper fault.

## Interface
- `D0`, default 10: largest denomination (8-bit value).
- `D1`, default 5: second denomination.
- `D2`, default 2: third denomination.
- `D3`, default 1: smallest denomination.
- `INIT_COUNT`, default 20: per-denomination inventory loaded at reset (8-bit).
- `TIMEOUT`, default 255: number of EJECT cycles without `eject_ready` before a fault is declared (8-bit, ≥1).

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `return_change`  in  1  request strobe; sampled only in IDLE.
- `change_value`  in  8  amount to pay out; captured with the request.
- `eject_ready`  in  1  hopper accepts the coin this cycle.
- `refill_en`  in  1  inventory add strobe.
- `refill_sel`  in  2  denomination index to refill (0 = D0 … 3 = D3).
- `refill_qty`  in  8  number of coins to add.
- `busy`  out  1  high in every state except IDLE.
- `eject_valid`  out  1  a coin eject is requested.
- `eject_sel`  out  2  denomination index of the requested coin.
- `done`  out  1  one-cycle completion pulse.
- `short`  out  1  qualifies `done`: change is not fully payable from inventory.
- `fault`  out  1  qualifies `done`: hopper timeout.
- `remaining`  out  8  amount still owed; meaningful when `done` is high.
- `count0`..`count3`  out  8 each  current inventory per denomination.

## Operation
- State machine: IDLE, SELECT, EJECT, DONE.
- **IDLE**
  - If `return_change` is high: load `remaining` ← `change_value`, clear `short`/`fault` status, go to SELECT.
  - Otherwise stay in IDLE.
- **SELECT** (combinational pick)
  - Choose the lowest index i such that Di ≤ `remaining` and `count_i` > 0.
  - If `remaining` == 0: go to DONE.
  - Else if no i qualifies: set `short`, go to DONE.
  - Else latch `eject_sel` = i, clear the timeout counter, go to EJECT.
- **EJECT**
  - `eject_valid` = 1; `eject_sel` is held stable.
  - On `eject_valid` && `eject_ready`: `remaining` -= D[sel], `count_sel` -= 1, go to SELECT.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT: set `fault`, go to DONE. No decrement and no subtraction occur on a timeout.
- **DONE**
  - `done` = 1 for one cycle, with `short`/`fault` valid alongside it. Go to IDLE.
- **Outputs**
  - Moore outputs: `eject_valid` = (state == EJECT); `busy` = (state != IDLE).
  - `done` = (state == DONE); `short` and `fault` are driven only while `done` is high.
- **Arithmetic**
  - `remaining` never underflows, because a coin is only selected when Di ≤ `remaining`.
  - Inventory is 8-bit and saturating.
- **Refill**
  - Accepted in any state: `count_sel` ← min(255, `count_sel` + `refill_qty`).
  - If a refill and a handshake decrement hit the same denomination in the same cycle: `count` ← min(255, `count` − 1 + `refill_qty`).
  - A refill seen during SELECT takes effect for the next SELECT, not the current one.
- **Requests while busy** are ignored; there is no queueing.
- **Reset, including mid-payout**
  - State → IDLE; `remaining` → 0; `eject_sel` → 0.
  - `eject_valid`, `done`, `short`, `fault`, `busy` → 0.
  - `count0`..`count3` → INIT_COUNT.
  - A coin in flight without a handshake is not counted.

## Timing
- **Request.** Request at cycle T (IDLE). SELECT at T+1. First `eject_valid` at T+2 at the earliest.
- **Per coin.** Each coin costs 2 cycles (SELECT + EJECT) when `eject_ready` is held high.
- **Zero request.** `change_value` = 0: `done` at T+2, IDLE at T+3, `eject_valid` never asserted.
- **Total latency.** `done` asserts one cycle after the final SELECT. With `eject_ready` held high, total latency = 2·N_coins + 2 cycles.
- **Timeout.** `fault` with `done` asserts TIMEOUT cycles after EJECT entry when `eject_ready` stays low.
- **Back-to-back requests.** A new request is accepted no earlier than the cycle after DONE.

## Test plan
- Reset with default inventory; request 17 with `eject_ready` held at 1. Required: ejects sel 0, 1, 2 (10 + 5 + 2) on cycles T+2, T+4, T+6; `done` at T+8 with `short` = 0 and `remaining` = 0; `count0`/`count1`/`count2` = 19.
- Request 0. Required: `done` at T+2, no eject, all counts unchanged.
- Set `count3` = 0 and `count2` = 0 (reset with INIT_COUNT = 0, then refill `count0` = 1); request 13. Required: one D0 eject, then `done` with `short` = 1 and `remaining` = 3.
- Request 5 with `eject_ready` held at 0 and TIMEOUT = 4. Required: `eject_valid` stays high with `eject_sel` = 1 for 4 cycles, then `done` with `fault` = 1; `count1` unchanged; `remaining` = 5.
- `count0` = 254; refill sel 0 with qty 5 in the same cycle as a D0 handshake. Required: `count0` = 255 (saturated). Also check that `return_change` pulsed while `busy` is ignored.
- Assert `rst_n` low while in EJECT. Required: all outputs 0 immediately, counts = INIT_COUNT, IDLE after release.

Source files
------------

// File: rtl/change_dispenser.sv
// Coin payout unit: captures a change request, greedily breaks it into coins,
// tracks per-denomination inventory and drives the hopper eject handshake.
module change_dispenser #(
    parameter int unsigned D0         = 10,
    parameter int unsigned D1         = 5,
    parameter int unsigned D2         = 2,
    parameter int unsigned D3         = 1,
    parameter int unsigned INIT_COUNT = 20,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       return_change,
    input  logic [7:0] change_value,
    input  logic       eject_ready,
    input  logic       refill_en,
    input  logic [1:0] refill_sel,
    input  logic [7:0] refill_qty,
    output logic       busy,
    output logic       eject_valid,
    output logic [1:0] eject_sel,
    output logic       done,
    output logic       short,
    output logic       fault,
    output logic [7:0] remaining,
    output logic [7:0] count0,
    output logic [7:0] count1,
    output logic [7:0] count2,
    output logic [7:0] count3
);

    localparam int unsigned W    = 8;
    localparam int unsigned SW   = 2;
    localparam int unsigned NDEN = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  remaining_next;
    logic [SW-1:0] sel_next;
    logic          short_flag;
    logic          short_flag_next;
    logic          fault_flag;
    logic          fault_flag_next;
    logic [W-1:0]  tmo_cnt;
    logic [W-1:0]  tmo_next;
    logic [W-1:0]  count_q    [NDEN];
    logic [W-1:0]  count_next [NDEN];
    logic [W-1:0]  denom      [NDEN];
    logic          pick_found_c;
    logic [SW-1:0] pick_sel_c;
    logic          handshake_c;

    assign denom[0] = W'(D0);
    assign denom[1] = W'(D1);
    assign denom[2] = W'(D2);
    assign denom[3] = W'(D3);

    assign count0 = count_q[0];
    assign count1 = count_q[1];
    assign count2 = count_q[2];
    assign count3 = count_q[3];

    assign handshake_c = (state == EJECT) && eject_ready;

    // Greedy pick: lowest index (largest coin) that fits and is in stock.
    always_comb begin
        pick_found_c = 1'b0;
        pick_sel_c   = '0;
        for (int i = NDEN - 1; i >= 0; i--) begin
            if ((denom[i] <= remaining) && (count_q[i] != '0)) begin
                pick_found_c = 1'b1;
                pick_sel_c   = SW'(i);
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_next      = state;
        remaining_next  = remaining;
        sel_next        = eject_sel;
        short_flag_next = short_flag;
        fault_flag_next = fault_flag;
        tmo_next        = tmo_cnt;
        case (state)
            IDLE: begin
                if (return_change) begin
                    remaining_next  = change_value;
                    short_flag_next = 1'b0;
                    fault_flag_next = 1'b0;
                    state_next      = SELECT;
                end
            end
            SELECT: begin
                if (remaining == '0) begin
                    state_next = DONE;
                end else if (!pick_found_c) begin
                    short_flag_next = 1'b1;
                    state_next      = DONE;
                end else begin
                    sel_next   = pick_sel_c;
                    tmo_next   = '0;
                    state_next = EJECT;
                end
            end
            EJECT: begin
                if (eject_ready) begin
                    remaining_next = remaining - denom[eject_sel];
                    state_next     = SELECT;
                end else if ((9'(tmo_cnt) + 9'd1) >= 9'(TIMEOUT)) begin
                    fault_flag_next = 1'b1;
                    state_next      = DONE;
                end else begin
                    tmo_next = tmo_cnt + W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Inventory: refill and handshake decrement combine, saturating at 255.
    always_comb begin
        logic [W:0] sum_c;
        sum_c = '0;
        for (int i = 0; i < NDEN; i++) begin
            sum_c = {1'b0, count_q[i]};
            if (handshake_c && (eject_sel == SW'(i))) begin
                sum_c = sum_c - (W+1)'(1);
            end
            if (refill_en && (refill_sel == SW'(i))) begin
                sum_c = sum_c + {1'b0, refill_qty};
            end
            count_next[i] = sum_c[W] ? '1 : sum_c[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            eject_sel   <= '0;
            short_flag  <= 1'b0;
            fault_flag  <= 1'b0;
            tmo_cnt     <= '0;
            busy        <= 1'b0;
            eject_valid <= 1'b0;
            done        <= 1'b0;
            short       <= 1'b0;
            fault       <= 1'b0;
            for (int i = 0; i < NDEN; i++) begin
                count_q[i] <= W'(INIT_COUNT);
            end
        end else begin
            state       <= state_next;
            remaining   <= remaining_next;
            eject_sel   <= sel_next;
            short_flag  <= short_flag_next;
            fault_flag  <= fault_flag_next;
            tmo_cnt     <= tmo_next;
            busy        <= (state_next != IDLE);
            eject_valid <= (state_next == EJECT);
            done        <= (state_next == DONE);
            short       <= (state_next == DONE) && short_flag_next;
            fault       <= (state_next == DONE) && fault_flag_next;
            for (int i = 0; i < NDEN; i++) begin
                count_q[i] <= count_next[i];
            end
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected ejects and
// completions; a negedge monitor pops and compares them as the DUTs present them.
module tb_change_dispenser;

    typedef struct packed {
        logic       s;
        logic       f;
        logic [7:0] rem;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
        int         cyc;
    } done_t;

    typedef struct packed {
        logic [1:0] sel;
        int         cyc;
    } ej_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    done_t dq_a[$];
    done_t dq_b[$];
    ej_t   eq_a[$];
    ej_t   eq_b[$];

    // DUT A: default inventory, short timeout
    logic       rst_n_a, rc_a, er_a, rf_en_a;
    logic [7:0] cv_a, rf_qty_a;
    logic [1:0] rf_sel_a;
    logic       busy_a, ev_a, done_a, short_a, fault_a;
    logic [1:0] es_a;
    logic [7:0] rem_a, c0_a, c1_a, c2_a, c3_a;

    // DUT B: empty inventory at reset
    logic       rst_n_b, rc_b, er_b, rf_en_b;
    logic [7:0] cv_b, rf_qty_b;
    logic [1:0] rf_sel_b;
    logic       busy_b, ev_b, done_b, short_b, fault_b;
    logic [1:0] es_b;
    logic [7:0] rem_b, c0_b, c1_b, c2_b, c3_b;

    change_dispenser #(.TIMEOUT(4)) u_a (
        .clk(clk), .rst_n(rst_n_a), .return_change(rc_a), .change_value(cv_a),
        .eject_ready(er_a), .refill_en(rf_en_a), .refill_sel(rf_sel_a), .refill_qty(rf_qty_a),
        .busy(busy_a), .eject_valid(ev_a), .eject_sel(es_a), .done(done_a),
        .short(short_a), .fault(fault_a), .remaining(rem_a),
        .count0(c0_a), .count1(c1_a), .count2(c2_a), .count3(c3_a)
    );

    change_dispenser #(.INIT_COUNT(0), .TIMEOUT(4)) u_b (
        .clk(clk), .rst_n(rst_n_b), .return_change(rc_b), .change_value(cv_b),
        .eject_ready(er_b), .refill_en(rf_en_b), .refill_sel(rf_sel_b), .refill_qty(rf_qty_b),
        .busy(busy_b), .eject_valid(ev_b), .eject_sel(es_b), .done(done_b),
        .short(short_b), .fault(fault_b), .remaining(rem_b),
        .count0(c0_b), .count1(c1_b), .count2(c2_b), .count3(c3_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_done(input int w, input logic s, input logic f, input logic [7:0] rem,
                            input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                            input logic [7:0] c3, input int at);
        done_t d;
        d = '{s: s, f: f, rem: rem, c0: c0, c1: c1, c2: c2, c3: c3, cyc: at};
        if (w == 0) dq_a.push_back(d);
        else        dq_b.push_back(d);
    endtask

    task automatic exp_ej(input int w, input logic [1:0] sel, input int at);
        ej_t e;
        e = '{sel: sel, cyc: at};
        if (w == 0) eq_a.push_back(e);
        else        eq_b.push_back(e);
    endtask

    task automatic mon_ej(input int w, input logic [1:0] sel);
        ej_t   e;
        string p;
        p = (w == 0) ? "a" : "b";
        if ((w == 0 && eq_a.size() == 0) || (w == 1 && eq_b.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_eject_unexpected: got eject sel %0d at cycle %0d, expected none", p, sel, cyc);
        end else begin
            e = (w == 0) ? eq_a.pop_front() : eq_b.pop_front();
            chk({p, "_eject_sel"}, int'(sel), int'(e.sel));
            chk({p, "_eject_cycle"}, cyc, e.cyc);
        end
    endtask

    task automatic mon_done(input int w, input logic s, input logic f, input logic [7:0] rem,
                            input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                            input logic [7:0] c3);
        done_t d;
        string p;
        p = (w == 0) ? "a" : "b";
        if ((w == 0 && dq_a.size() == 0) || (w == 1 && dq_b.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_done_unexpected: got done at cycle %0d, expected none", p, cyc);
        end else begin
            d = (w == 0) ? dq_a.pop_front() : dq_b.pop_front();
            chk({p, "_done_cycle"}, cyc, d.cyc);
            chk({p, "_short"}, int'(s), int'(d.s));
            chk({p, "_fault"}, int'(f), int'(d.f));
            chk({p, "_remaining"}, int'(rem), int'(d.rem));
            chk({p, "_count0"}, int'(c0), int'(d.c0));
            chk({p, "_count1"}, int'(c1), int'(d.c1));
            chk({p, "_count2"}, int'(c2), int'(d.c2));
            chk({p, "_count3"}, int'(c3), int'(d.c3));
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents an eject or completion.
    always @(negedge clk) begin
        if (rst_n_a === 1'b1) begin
            if (ev_a) mon_ej(0, es_a);
            if (done_a) mon_done(0, short_a, fault_a, rem_a, c0_a, c1_a, c2_a, c3_a);
            else if (short_a || fault_a) chk("a_status_without_done", int'({short_a, fault_a}), 0);
        end
        if (rst_n_b === 1'b1) begin
            if (ev_b) mon_ej(1, es_b);
            if (done_b) mon_done(1, short_b, fault_b, rem_b, c0_b, c1_b, c2_b, c3_b);
            else if (short_b || fault_b) chk("b_status_without_done", int'({short_b, fault_b}), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int w);
        int k;
        k = 0;
        while (((w == 0) ? busy_a : busy_b) && k < 200) begin
            tick();
            k++;
        end
        chk((w == 0) ? "a_idle_wait_expired" : "b_idle_wait_expired",
            int'((w == 0) ? busy_a : busy_b), 0);
    endtask

    task automatic req(input int w, input logic [7:0] v);
        if (w == 0) begin rc_a = 1'b1; cv_a = v; end
        else        begin rc_b = 1'b1; cv_b = v; end
        tick();
        rc_a = 1'b0;
        rc_b = 1'b0;
    endtask

    task automatic refill(input int w, input logic [1:0] sel, input logic [7:0] qty);
        if (w == 0) begin rf_en_a = 1'b1; rf_sel_a = sel; rf_qty_a = qty; end
        else        begin rf_en_b = 1'b1; rf_sel_b = sel; rf_qty_b = qty; end
        tick();
        rf_en_a = 1'b0;
        rf_en_b = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n_a = 1'b0; rc_a = 1'b0; cv_a = '0; er_a = 1'b1; rf_en_a = 1'b0; rf_sel_a = '0; rf_qty_a = '0;
        rst_n_b = 1'b0; rc_b = 1'b0; cv_b = '0; er_b = 1'b1; rf_en_b = 1'b0; rf_sel_b = '0; rf_qty_b = '0;
        repeat (2) tick();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();

        // Reset state
        chk("a_reset_busy", int'(busy_a), 0);
        chk("a_reset_eject_valid", int'(ev_a), 0);
        chk("a_reset_done", int'(done_a), 0);
        chk("a_reset_remaining", int'(rem_a), 0);
        chk("a_reset_count0", int'(c0_a), 20);
        chk("a_reset_count3", int'(c3_a), 20);
        chk("b_reset_count0", int'(c0_b), 0);

        // 17 = 10 + 5 + 2 with the hopper always ready
        t = cyc;
        exp_ej(0, 2'd0, t + 2);
        exp_ej(0, 2'd1, t + 4);
        exp_ej(0, 2'd2, t + 6);
        exp_done(0, 1'b0, 1'b0, 8'd0, 8'd19, 8'd19, 8'd19, 8'd20, t + 8);
        req(0, 8'd17);
        wait_idle(0);

        // Zero request: immediate completion, no eject
        t = cyc;
        exp_done(0, 1'b0, 1'b0, 8'd0, 8'd19, 8'd19, 8'd19, 8'd20, t + 2);
        req(0, 8'd0);
        wait_idle(0);

        // Hopper stalls: eject held for TIMEOUT cycles, then fault
        er_a = 1'b0;
        t = cyc;
        for (int i = 2; i <= 5; i++) exp_ej(0, 2'd1, t + i);
        exp_done(0, 1'b0, 1'b1, 8'd5, 8'd19, 8'd19, 8'd19, 8'd20, t + 6);
        req(0, 8'd5);
        wait_idle(0);
        er_a = 1'b1;

        // Refill to 254, then refill coincident with a D0 handshake saturates
        refill(0, 2'd0, 8'd235);
        chk("a_refill_count0", int'(c0_a), 254);
        t = cyc;
        exp_ej(0, 2'd0, t + 2);
        exp_done(0, 1'b0, 1'b0, 8'd0, 8'd255, 8'd19, 8'd19, 8'd20, t + 4);
        req(0, 8'd10);
        tick();
        rf_en_a = 1'b1; rf_sel_a = 2'd0; rf_qty_a = 8'd5;
        tick();
        rf_en_a = 1'b0;
        rc_a = 1'b1; cv_a = 8'd7;
        repeat (2) tick();
        rc_a = 1'b0;
        wait_idle(0);
        repeat (6) tick();
        chk("a_busy_request_ignored", int'(busy_a), 0);

        // Reset while ejecting
        er_a = 1'b0;
        t = cyc;
        exp_ej(0, 2'd1, t + 2);
        req(0, 8'd5);
        tick();
        @(negedge clk);
        #1 rst_n_a = 1'b0;
        #1;
        chk("a_midreset_busy", int'(busy_a), 0);
        chk("a_midreset_eject_valid", int'(ev_a), 0);
        chk("a_midreset_eject_sel", int'(es_a), 0);
        chk("a_midreset_done", int'(done_a), 0);
        chk("a_midreset_status", int'({short_a, fault_a}), 0);
        chk("a_midreset_remaining", int'(rem_a), 0);
        chk("a_midreset_count0", int'(c0_a), 20);
        chk("a_midreset_count1", int'(c1_a), 20);
        chk("a_midreset_count2", int'(c2_a), 20);
        repeat (2) tick();
        rst_n_a = 1'b1;
        er_a = 1'b1;
        tick();
        chk("a_postreset_busy", int'(busy_a), 0);
        t = cyc;
        exp_ej(0, 2'd2, t + 2);
        exp_ej(0, 2'd3, t + 4);
        exp_done(0, 1'b0, 1'b0, 8'd0, 8'd20, 8'd20, 8'd19, 8'd19, t + 6);
        req(0, 8'd3);
        wait_idle(0);

        // Empty inventory except one D0 coin
        refill(1, 2'd0, 8'd1);
        t = cyc;
        exp_done(1, 1'b1, 1'b0, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, t + 2);
        req(1, 8'd4);
        wait_idle(1);
        t = cyc;
        exp_ej(1, 2'd0, t + 2);
        exp_done(1, 1'b1, 1'b0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, t + 4);
        req(1, 8'd13);
        wait_idle(1);

        // Plain refill saturation
        refill(1, 2'd3, 8'd200);
        refill(1, 2'd3, 8'd200);
        chk("b_refill_saturate", int'(c3_b), 255);

        repeat (5) tick();
        chk("a_eject_queue_drained", eq_a.size(), 0);
        chk("a_done_queue_drained", dq_a.size(), 0);
        chk("b_eject_queue_drained", eq_b.size(), 0);
        chk("b_done_queue_drained", dq_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
